// File: rtl/hex_disp_arbiter.sv
// Two-requester arbiter for the shared 7-segment display: grants ownership with a
// minimum hold time on contention, forwards the owner's value and flags value changes.
module hex_disp_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic [31:0] a_data,
  input  logic        b_req,
  input  logic [31:0] b_data,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic [31:0] disp_data,
  output logic        disp_update
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_b_q, last_b_d;
  logic [31:0]      disp_q, disp_d;
  logic             update_q, update_d;
  logic             hold_done;
  logic             entering_own;

  assign hold_done    = (cnt_q == CNT_MAX);
  assign entering_own = (state_d != ST_IDLE) && (state_d != state_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a tie from idle goes to whoever did not own last
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (a_req && b_req) begin
          state_d = last_b_q ? ST_OWN_A : ST_OWN_B;
        end else if (a_req) begin
          state_d = ST_OWN_A;
        end else if (b_req) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (!a_req) begin
          state_d = b_req ? ST_OWN_B : ST_IDLE;
        end else if (b_req && hold_done) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_B: begin
        if (!b_req) begin
          state_d = a_req ? ST_OWN_A : ST_IDLE;
        end else if (a_req && hold_done) begin
          state_d = ST_OWN_A;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: grants decode straight from the registered state
  always_comb begin
    a_gnt = (state_q == ST_OWN_A);
    b_gnt = (state_q == ST_OWN_B);
  end

  // Datapath next-state: hold counter, last owner, display value and change flag
  always_comb begin
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    disp_d   = disp_q;
    if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end else if (entering_own) begin
      cnt_d    = '0;
      last_b_d = (state_d == ST_OWN_B);
    end else if (!hold_done) begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state_d)
      ST_OWN_A: disp_d = a_data;
      ST_OWN_B: disp_d = b_data;
      default:  disp_d = disp_q;
    endcase
    update_d = (disp_d != disp_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      disp_q   <= 32'h0;
      update_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      disp_q   <= disp_d;
      update_q <= update_d;
    end
  end

  assign disp_data   = disp_q;
  assign disp_update = update_q;

endmodule
